spn_round_ctrl: RTL and testbench
=================================

// Module: spn_round_ctrl
// PURPOSE
//  Iterative SPN round engine that drives the 16-nibble permutation stages (randomWiring1/2/3).
//  Each round it computes key-add + nibble S-box, presents the result to the external
//  permutation stage, and registers what comes back as the next state.
//  It sits on both sides of the wiring: it feeds wire_a and consumes wire_b.
//  Streams 64-bit blocks in and out over valid/ready handshakes.
// PARAMETERS
//  NIBBLES   16  nibble lanes per block; block width = NIBBLES*4
//  ROUNDS    12  rounds per block, range 1..15
// PORTS
//  clk        in   1   single clock, rising edge
//  rst_n      in   1   asynchronous active-low reset
//  in_valid   in   1   input block offered
//  in_ready   out  1   engine can accept a block
//  in_data    in   64  plaintext block; nibble i = bits [4i+3:4i]
//  key        in   64  block key; sampled on the input handshake
//  wire_a     out  64  S-box layer output, to the permutation stage A bus
//  wire_sel   out  2   permutation select: 0/1/2 = wiring 1/2/3 (external mux)
//  wire_b     in   64  permuted result from the permutation stage B bus (combinational return)
//  out_valid  out  1   result block available
//  out_ready  in   1   consumer accepts the result
//  out_data   out  64  ciphertext block
// BEHAVIOUR
//  - Reset, async: FSM=IDLE; in_ready=1; out_valid=0; out_data=0; wire_a=0; wire_sel=0;
//    state reg, key reg and round counter r cleared.
//  - Round key: rk(r) = rotl(key_q, 4*r) ^ {60'b0, r[3:0]}.
//  - sbox(x) applies S[] per nibble. S = C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
//  - FSM:
//    IDLE: in_ready=1. On in_valid&in_ready: state<=in_data, key_q<=key, r<=0 -> RUN.
//    RUN:  in_ready=0. wire_a = sbox(state ^ rk(r)), driven combinationally from registers.
//          wire_sel = r mod 3. Each cycle: state<=wire_b, r<=r+1.
//          When r==ROUNDS-1: out_data<=wire_b ^ rk(ROUNDS), out_valid<=1 -> DONE.
//    DONE: out_valid=1, with out_data stable until out_valid&out_ready, then -> IDLE.
//          in_ready=0 throughout DONE.
//  - Latency: input handshake to out_valid = ROUNDS+1 cycles.
//    Throughput: one block per ROUNDS+2 cycles when out_ready is held high.
//  - in_valid is ignored outside IDLE; no input is buffered or dropped silently (in_ready=0).
//  - out_ready low in DONE stalls indefinitely; out_data and out_valid are held.
//  - wire_a and wire_sel are don't-care outside RUN but must be driven deterministically:
//    wire_a=0, wire_sel=0.
//  - Reset mid-RUN or mid-DONE discards the block immediately; no partial output.
//  - r wraps never: it is bounded by ROUNDS<=15 and is 4 bits wide.
//  - wire_b must be a pure combinational function of wire_a and wire_sel (no loop through clk).
// STRUCTURE
//  - Package spn_pkg: SBOX[16] constant, BLOCK_W=64, NIB_W=4, fsm_t enum {IDLE,RUN,DONE},
//    function sbox_layer(64b), function round_key(key,r).
//  - One sub-module: spn_sbox_layer (16 parallel 4-bit S-box lookups, combinational).
//  - The permutation mux lives outside this block, in the integration top.
// TESTING
//  Bench stubs the permutation stage as identity unless noted.
//  1. ROUNDS=1, key=0, in_data=0 -> wire_a=0xCCCC_CCCC_CCCC_CCCC while in RUN;
//     out_data=0xCCCC_CCCC_CCCC_CCCD, out_valid at cycle 2 after the handshake.
//  2. ROUNDS=4, real wiring mux -> wire_sel sequence 0,1,2,0 over the 4 RUN cycles;
//     out_data matches the reference-model value.
//  3. out_ready=0 for 10 cycles in DONE -> out_valid=1 and out_data constant;
//     in_ready=0 throughout; accepted on the first out_ready=1 cycle.
//  4. in_valid held high during RUN with different in_data -> no accept;
//     first block's result is unchanged; second block is accepted in the first IDLE cycle.
//  5. rst_n pulsed low at RUN round 2 -> all outputs at reset values immediately;
//     next block processes correctly from round 0.
//  6. Back-to-back blocks, out_ready=1, ROUNDS=12 -> in handshakes exactly 14 cycles apart;
//     results match the model for key=0x0123_4567_89AB_CDEF.

Source files
------------

// File: rtl/spn_pkg.sv
// Shared constants, FSM encoding and round helpers for the SPN round controller.
package spn_pkg;

   localparam int BLOCK_W = 64;
   localparam int NIB_W   = 4;

   localparam logic [3:0] SBOX [16] = '{
      4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
      4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
   };

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } fsm_t;

   function automatic logic [BLOCK_W-1:0] sbox_layer(input logic [BLOCK_W-1:0] x);
      logic [BLOCK_W-1:0] y;
      y = '0;
      for (int i = 0; i < BLOCK_W / NIB_W; i++) begin
         y[i*NIB_W +: NIB_W] = SBOX[x[i*NIB_W +: NIB_W]];
      end
      return y;
   endfunction

   // Rotate left by whole nibbles, then fold the round index into the low nibble.
   function automatic logic [BLOCK_W-1:0] round_key(input logic [BLOCK_W-1:0] key,
                                                    input logic [3:0]         r);
      logic [2*BLOCK_W-1:0] t;
      t = {key, key} << (NIB_W * r);
      return t[2*BLOCK_W-1 -: BLOCK_W] ^ BLOCK_W'(r);
   endfunction

endpackage

// File: rtl/spn_sbox_layer.sv
// Parallel 4-bit S-box lookup across every nibble lane; purely combinational.
module spn_sbox_layer
   import spn_pkg::*;
#(
   parameter int NIBBLES = 16
) (
   input  logic [NIBBLES*NIB_W-1:0] x,
   output logic [NIBBLES*NIB_W-1:0] y
);

   for (genvar i = 0; i < NIBBLES; i++) begin : g_lane
      assign y[i*NIB_W +: NIB_W] = SBOX[x[i*NIB_W +: NIB_W]];
   end

endmodule

// File: rtl/spn_round_ctrl.sv
// Iterative SPN round engine: key-add and S-box per round, permutation applied externally
// via wire_a/wire_sel -> wire_b, with blocks streamed in and out over valid/ready.
module spn_round_ctrl
   import spn_pkg::*;
#(
   parameter int NIBBLES = 16,
   parameter int ROUNDS  = 12
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [NIBBLES*NIB_W-1:0] in_data,
   input  logic [NIBBLES*NIB_W-1:0] key,
   output logic [NIBBLES*NIB_W-1:0] wire_a,
   output logic [1:0]               wire_sel,
   input  logic [NIBBLES*NIB_W-1:0] wire_b,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [NIBBLES*NIB_W-1:0] out_data
);

   localparam int         W       = NIBBLES * NIB_W;
   localparam logic [3:0] LAST_R  = 4'(ROUNDS - 1);
   localparam logic [3:0] FINAL_R = 4'(ROUNDS);

   // Valid/ready: a word moves on a rising edge where both are high. in_ready is a pure
   // function of FSM state; out_valid and out_data stay put until the consumer accepts.
   fsm_t         fsm_q, fsm_d;
   logic [W-1:0] state_q, key_q, out_data_q;
   logic [W-1:0] rk, sb_in, sb_out;
   logic [3:0]   r_q;
   logic         last_round;

   assign rk         = round_key(key_q, r_q);
   assign sb_in      = state_q ^ rk;
   assign last_round = (r_q == LAST_R);
   assign out_data   = out_data_q;

   spn_sbox_layer #(.NIBBLES(NIBBLES)) u_sbox (
      .x (sb_in),
      .y (sb_out)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) fsm_q <= IDLE;
      else        fsm_q <= fsm_d;
   end

   // wire_a/wire_sel are forced to zero outside RUN so the external mux sees a quiet bus.
   always_comb begin
      fsm_d     = fsm_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      wire_a    = '0;
      wire_sel  = 2'd0;
      case (fsm_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) fsm_d = RUN;
         end
         RUN: begin
            wire_a   = sb_out;
            wire_sel = 2'(r_q % 4'd3);
            if (last_round) fsm_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) fsm_d = IDLE;
         end
         default: fsm_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= '0;
         key_q      <= '0;
         r_q        <= '0;
         out_data_q <= '0;
      end else begin
         case (fsm_q)
            IDLE: begin
               if (in_valid) begin
                  state_q <= in_data;
                  key_q   <= key;
                  r_q     <= '0;
               end
            end
            RUN: begin
               state_q <= wire_b;
               r_q     <= r_q + 4'd1;
               if (last_round) out_data_q <= wire_b ^ round_key(key_q, FINAL_R);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_spn_round_ctrl.sv
// Bench for spn_round_ctrl: three instances (ROUNDS 1, 4, 12) with a stand-in permutation
// stage, checked against a block-level cipher model.
module tb_spn_round_ctrl;

   localparam int NI = 3;
   localparam logic [3:0] SB_M [16] = '{
      4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
      4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
   };

   logic        clk;
   logic        rst_n;
   logic        in_valid  [NI];
   logic        in_ready  [NI];
   logic        out_valid [NI];
   logic        out_ready [NI];
   logic [63:0] in_data   [NI];
   logic [63:0] key_in    [NI];
   logic [63:0] wire_a    [NI];
   logic [63:0] wire_b    [NI];
   logic [63:0] out_data  [NI];
   logic [1:0]  wire_sel  [NI];
   logic        use_perm  [NI];

   logic [63:0] exp_q [$];
   int          n_tests;
   int          n_fail;
   int          cyc;

   // ---------------- reference model ----------------
   function automatic int rounds_of(input int g);
      case (g)
         0:       return 1;
         1:       return 4;
         default: return 12;
      endcase
   endfunction

   function automatic logic [63:0] sbox_m(input logic [63:0] x);
      logic [63:0] y;
      for (int i = 0; i < 16; i++) y[4*i +: 4] = SB_M[x[4*i +: 4]];
      return y;
   endfunction

   function automatic logic [63:0] rk_m(input logic [63:0] k, input int r);
      logic [127:0] t;
      t = {k, k} << (4 * r);
      return t[127:64] ^ 64'(r);
   endfunction

   // Stand-in for wiring 1/2/3: fixed nibble permutations, output nibble i <- input nibble src.
   function automatic logic [63:0] perm_m(input logic [63:0] x, input logic [1:0] sel);
      logic [63:0] y;
      int mul, add, src;
      case (sel)
         2'd0:    begin mul = 5;  add = 3; end
         2'd1:    begin mul = 7;  add = 1; end
         2'd2:    begin mul = 11; add = 6; end
         default: begin mul = 1;  add = 0; end
      endcase
      for (int i = 0; i < 16; i++) begin
         src = (mul * i + add) % 16;
         y[4*i +: 4] = x[4*src +: 4];
      end
      return y;
   endfunction

   function automatic logic [63:0] model_block(input logic [63:0] d, input logic [63:0] k,
                                               input int rounds, input logic perm);
      logic [63:0] x, s;
      x = d;
      for (int i = 0; i < rounds; i++) begin
         s = sbox_m(x ^ rk_m(k, i));
         x = perm ? perm_m(s, 2'(i % 3)) : s;
      end
      return x ^ rk_m(k, rounds);
   endfunction

   // ---------------- clock / reset / DUTs ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int RG = (g == 0) ? 1 : (g == 1) ? 4 : 12;
      spn_round_ctrl #(.NIBBLES(16), .ROUNDS(RG)) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (in_valid[g]),
         .in_ready  (in_ready[g]),
         .in_data   (in_data[g]),
         .key       (key_in[g]),
         .wire_a    (wire_a[g]),
         .wire_sel  (wire_sel[g]),
         .wire_b    (wire_b[g]),
         .out_valid (out_valid[g]),
         .out_ready (out_ready[g]),
         .out_data  (out_data[g])
      );
      assign wire_b[g] = use_perm[g] ? perm_m(wire_a[g], wire_sel[g]) : wire_a[g];
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   // ---------------- checking ----------------
   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic check_reset(input int g);
      check_eq("rst_in_ready",  64'(in_ready[g]),  64'd1);
      check_eq("rst_out_valid", 64'(out_valid[g]), 64'd0);
      check_eq("rst_out_data",  out_data[g],       64'd0);
      check_eq("rst_wire_a",    wire_a[g],         64'd0);
      check_eq("rst_wire_sel",  64'(wire_sel[g]),  64'd0);
   endtask

   // ---------------- driver ----------------
   // Entered and left just after a falling edge. With hold set, in_valid stays high with d2
   // through RUN/DONE so the next block is offered in the first IDLE cycle.
   task automatic do_block(input int g, input logic [63:0] d, input logic [63:0] k,
                           input int stall, input bit hold, input logic [63:0] d2,
                           output int waited, output int hs_cyc);
      int          r;
      logic [63:0] x, ea, exp;
      r           = rounds_of(g);
      waited      = 0;
      hs_cyc      = 0;
      in_valid[g] = 1'b1;
      in_data[g]  = d;
      key_in[g]   = k;
      out_ready[g] = (stall == 0);
      while (!in_ready[g] && waited < 64) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready[g]) begin
         check_eq("hs_timeout", 64'd0, 64'd1);
         in_valid[g] = 1'b0;
         return;
      end
      exp_q.push_back(model_block(d, k, r, use_perm[g]));
      @(negedge clk);
      hs_cyc    = cyc;
      key_in[g] = {$urandom, $urandom};
      if (hold) in_data[g] = d2;
      else      in_valid[g] = 1'b0;
      x = d;
      for (int i = 0; i < r; i++) begin
         ea = sbox_m(x ^ rk_m(k, i));
         check_eq("run_wire_a",    wire_a[g],         ea);
         check_eq("run_wire_sel",  64'(wire_sel[g]),  64'(i % 3));
         check_eq("run_in_ready",  64'(in_ready[g]),  64'd0);
         check_eq("run_out_valid", 64'(out_valid[g]), 64'd0);
         x = use_perm[g] ? perm_m(ea, 2'(i % 3)) : ea;
         @(negedge clk);
      end
      exp = exp_q.pop_front();
      check_eq("done_out_valid", 64'(out_valid[g]), 64'd1);
      check_eq("done_out_data",  out_data[g],       exp);
      check_eq("done_in_ready",  64'(in_ready[g]),  64'd0);
      check_eq("done_wire_a",    wire_a[g],         64'd0);
      check_eq("done_wire_sel",  64'(wire_sel[g]),  64'd0);
      for (int s = 1; s < stall; s++) begin
         @(negedge clk);
         check_eq("stall_out_valid", 64'(out_valid[g]), 64'd1);
         check_eq("stall_out_data",  out_data[g],       exp);
         check_eq("stall_in_ready",  64'(in_ready[g]),  64'd0);
      end
      out_ready[g] = 1'b1;
      @(negedge clk);
      check_eq("acc_out_valid", 64'(out_valid[g]), 64'd0);
      check_eq("acc_in_ready",  64'(in_ready[g]),  64'd1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int          w, h1, h2;
      logic [63:0] d2;
      n_tests = 0;
      n_fail  = 0;
      rst_n   = 1'b0;
      for (int g = 0; g < NI; g++) begin
         in_valid[g]  = 1'b0;
         out_ready[g] = 1'b0;
         in_data[g]   = '0;
         key_in[g]    = '0;
         use_perm[g]  = 1'b0;
      end
      use_perm[1] = 1'b1;
      repeat (3) @(negedge clk);
      for (int g = 0; g < NI; g++) check_reset(g);
      rst_n = 1'b1;
      @(negedge clk);

      // single round, all-zero block and key
      do_block(0, 64'd0, 64'd0, 0, 1'b0, 64'd0, w, h1);
      check_eq("t1_out_const", out_data[0], 64'hCCCC_CCCC_CCCC_CCCD);

      // four rounds through the permutation stand-in
      do_block(1, {$urandom, $urandom}, {$urandom, $urandom}, 0, 1'b0, 64'd0, w, h1);

      // output back-pressure for 10 cycles
      do_block(2, {$urandom, $urandom}, {$urandom, $urandom}, 10, 1'b0, 64'd0, w, h1);

      // in_valid held through RUN with a different block
      d2 = {$urandom, $urandom};
      do_block(2, {$urandom, $urandom}, {$urandom, $urandom}, 0, 1'b1, d2, w, h1);
      do_block(2, d2, {$urandom, $urandom}, 0, 1'b0, 64'd0, w, h1);
      check_eq("t4_first_idle_accept", 64'(w), 64'd0);

      // reset pulse at round 2 of a block
      in_valid[2] = 1'b1;
      in_data[2]  = {$urandom, $urandom};
      key_in[2]   = {$urandom, $urandom};
      @(negedge clk);
      in_valid[2] = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("t5_round2_sel", 64'(wire_sel[2]), 64'd2);
      #2 rst_n = 1'b0;
      #1 check_reset(2);
      @(negedge clk);
      rst_n = 1'b1;
      do_block(2, {$urandom, $urandom}, {$urandom, $urandom}, 0, 1'b0, 64'd0, w, h1);

      // back-to-back blocks with a fixed key
      do_block(2, {$urandom, $urandom}, 64'h0123_4567_89AB_CDEF, 0, 1'b0, 64'd0, w, h1);
      do_block(2, {$urandom, $urandom}, 64'h0123_4567_89AB_CDEF, 0, 1'b0, 64'd0, w, h2);
      check_eq("t6_hs_spacing", 64'(h2 - h1), 64'd14);

      // randomized blocks, permutation active on every instance
      use_perm[0] = 1'b1;
      use_perm[2] = 1'b1;
      for (int n = 0; n < 6; n++) begin
         for (int g = 0; g < NI; g++) begin
            do_block(g, {$urandom, $urandom}, {$urandom, $urandom},
                     $urandom_range(0, 4), 1'b0, 64'd0, w, h1);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
